tx_frame_seq: RTL

Parametrised transmit-frame sequencer for the MIL-STD-1553-style TX path.
- On a start strobe it asserts txen for a whole frame: one command word (CW) followed by a programmable number of data words (DW).
- Each word is presented on DAT for a fixed number of clocks.
- Feeds the downstream serialiser/encoder, replacing the fixed single-window txen generator with a counted, multi-word frame.

---
 rtl/tx_frame_seq_if.sv | 24 ++
 rtl/tx_frame_seq.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/tx_frame_seq_if.sv
// Handshake/data bundle between the TX frame sequencer and its controller.
// The master drives the start strobe and word count; the slave returns the frame outputs.
interface tx_frame_seq_if #(
    parameter int W = 16
);
    logic         st;
    logic [3:0]   nwords;
    logic         txen;
    logic         busy;
    logic [W-1:0] DAT;
    logic         is_cw;
    logic [3:0]   word_idx;
    logic         done;

    modport master (
        output st, nwords,
        input  txen, busy, DAT, is_cw, word_idx, done
    );

    modport slave (
        input  st, nwords,
        output txen, busy, DAT, is_cw, word_idx, done
    );
endinterface

// File: rtl/tx_frame_seq.sv
// Transmit-frame sequencer: one command word followed by up to N_MAX data words, each held WORD_CYC clocks.
// Optional macro RETRIGGER_EN: a start strobe while busy restarts the frame instead of being ignored.
module tx_frame_seq #(
    parameter int           W        = 16,
    parameter int           WORD_CYC = 1000,
    parameter int           N_MAX    = 8,
    parameter logic [W-1:0] CW_VAL   = 16'h3344,
    parameter logic [W-1:0] DW_BASE  = 16'hBCDE
) (
    input  logic            clk,
    input  logic            rst,
    tx_frame_seq_if.slave   bus
);
    localparam int                CNT_W    = $clog2(WORD_CYC);
    localparam logic [CNT_W-1:0]  SLOT_END = CNT_W'(WORD_CYC - 1);
    localparam logic [3:0]        NMAX4    = 4'(N_MAX);

    typedef enum logic [1:0] {
        IDLE,
        CW,
        DW
    } state_t;

    state_t           state_q, state_n;
    logic [CNT_W-1:0] cnt_q, cnt_n;
    logic [3:0]       k_q, k_n;
    logic [3:0]       nw_q, nw_n;
    logic             txen_q, txen_n;
    logic [W-1:0]     dat_q, dat_n;
    logic             is_cw_q, is_cw_n;
    logic [3:0]       idx_q, idx_n;
    logic             done_q, done_n;
    logic             accept;
    logic             retrig;
    logic             slot_end;

`ifdef RETRIGGER_EN
    assign retrig = bus.st;
`else
    assign retrig = 1'b0;
`endif

    assign slot_end = (cnt_q == SLOT_END);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            k_q     <= '0;
            nw_q    <= '0;
            txen_q  <= 1'b0;
            dat_q   <= '0;
            is_cw_q <= 1'b0;
            idx_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_n;
            cnt_q   <= cnt_n;
            k_q     <= k_n;
            nw_q    <= nw_n;
            txen_q  <= txen_n;
            dat_q   <= dat_n;
            is_cw_q <= is_cw_n;
            idx_q   <= idx_n;
            done_q  <= done_n;
        end
    end

    // Outputs are computed one cycle ahead so every visible signal comes straight from a flop.
    always_comb begin
        state_n = state_q;
        cnt_n   = cnt_q;
        k_n     = k_q;
        nw_n    = nw_q;
        txen_n  = txen_q;
        dat_n   = dat_q;
        is_cw_n = is_cw_q;
        idx_n   = idx_q;
        done_n  = 1'b0;
        accept  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.st) begin
                    accept = 1'b1;
                end
            end
            CW: begin
                if (retrig) begin
                    accept = 1'b1;
                end else if (slot_end) begin
                    cnt_n = '0;
                    if (nw_q == 4'd0) begin
                        state_n = IDLE;
                        txen_n  = 1'b0;
                        dat_n   = '0;
                        is_cw_n = 1'b0;
                        idx_n   = '0;
                        done_n  = 1'b1;
                    end else begin
                        state_n = DW;
                        k_n     = '0;
                        dat_n   = DW_BASE;
                        is_cw_n = 1'b0;
                        idx_n   = 4'd1;
                    end
                end else begin
                    cnt_n = cnt_q + CNT_W'(1);
                end
            end
            DW: begin
                if (retrig) begin
                    accept = 1'b1;
                end else if (slot_end) begin
                    cnt_n = '0;
                    if (k_q == nw_q - 4'd1) begin
                        state_n = IDLE;
                        txen_n  = 1'b0;
                        dat_n   = '0;
                        idx_n   = '0;
                        k_n     = '0;
                        done_n  = 1'b1;
                    end else begin
                        k_n   = k_q + 4'd1;
                        dat_n = DW_BASE + W'(k_q) + W'(1);
                        idx_n = k_q + 4'd2;
                    end
                end else begin
                    cnt_n = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        // Accepting a start (fresh or retriggered) always lands on the command-word slot.
        if (accept) begin
            state_n = CW;
            cnt_n   = '0;
            k_n     = '0;
            nw_n    = (bus.nwords > NMAX4) ? NMAX4 : bus.nwords;
            txen_n  = 1'b1;
            dat_n   = CW_VAL;
            is_cw_n = 1'b1;
            idx_n   = '0;
        end
    end

    assign bus.txen     = txen_q;
    assign bus.busy     = txen_q;
    assign bus.DAT      = dat_q;
    assign bus.is_cw    = is_cw_q;
    assign bus.word_idx = idx_q;
    assign bus.done     = done_q;
endmodule
